ans_encoder: RTL
================

Name: ans_encoder

Overview:
- rANS encoder; the stage directly upstream of ans_decoder.
- Consumes a symbol stream and queries the shared frequency-model table over the same read_type/read_query port protocol as the decoder.
- Emits a nibble stream in exactly the order ans_decoder consumes it: final state first (low nibble first), then renormalisation nibbles in LIFO order.
- Host supplies each message's symbols in reverse order; the decoder reproduces them forward.

Parameters:
SYM_WIDTH, 4, symbol and output nibble width (matches global `SYM_WIDTH)
CNT_WIDTH, 8, model count width (matches `CNT_WIDTH)
STATE_WIDTH, 16, coder state width, multiple of SYM_WIDTH (matches `STATE_WIDTH)
STACK_DEPTH, 32, renormalisation LIFO depth in nibbles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  clock enable; all state frozen when low
in  in  SYM_WIDTH  input symbol
in_last  in  1  marks final symbol of message, qualified with in_vld
in_vld  in  1  symbol valid
in_rdy  out  1  encoder ready for symbol
out  out  SYM_WIDTH  output nibble
out_vld  out  1  nibble valid
out_rdy  in  1  downstream accepts nibble
read_type  out  2  model query type: READ_TYPE_NONE/CMF/PMF/ICMF
read_query  out  CNT_WIDTH+SYM_WIDTH  model query argument
read_result  in  CNT_WIDTH+SYM_WIDTH  model answer, valid when read_rdy
read_rdy  in  1  model answer valid
err_ovf  out  1  sticky LIFO overflow

Behaviour:
- Reset values: in_rdy=0, out_vld=0, out=0, read_type=NONE, read_query=0, err_ovf=0, LIFO empty, state=INIT.
- Transfers: in and out transfer on a rising edge with vld&&rdy.
- After every out transfer, out_vld is held low for at least one cycle. This matches the decoder's drop-and-re-raise handshake.
- Model port: drive read_type/read_query and hold until read_rdy=1. Sample read_result in that cycle. Return read_type to NONE the next cycle.
- INIT: query CMF(SYM_COUNT-1), latch M. Set x=M. Go to IDLE.
- IDLE: in_rdy=1. On transfer, latch s and last, drop in_rdy, go to GET_PMF.
- GET_PMF: query PMF(s), latch f.
  - If f==0, set err_ovf and discard the symbol (go to IDLE or FLUSH_STATE per last).
  - If s==0, set c=0 and skip GET_CMF.
- GET_CMF: query CMF(s-1), latch c.
- RENORM: one nibble per cycle while x >= (f << SYM_WIDTH).
  - Push x[SYM_WIDTH-1:0] to LIFO.
  - x = x >> SYM_WIDTH.
  - Push when LIFO full: nibble dropped, err_ovf=1, shift still performed.
- ENCODE (1 cycle): x = (x/f)*M + c + (x%f), truncated to STATE_WIDTH. Then go to FLUSH_STATE if last, else IDLE.
- FLUSH_STATE: emit STATE_WIDTH/SYM_WIDTH nibbles of x, low nibble first.
- FLUSH_STACK: pop and emit until the LIFO is empty. Then go to INIT; x is reset to M for the next message.
- Invariant: x stays in [M, 16M) between symbols. This holds when M <= 2^(STATE_WIDTH-SYM_WIDTH).
- out_rdy low: out and out_vld hold stable.
- in_vld while not in IDLE: ignored; in_rdy=0.
- Reset mid-message: everything returns to reset values, LIFO cleared, no partial output.
- err_ovf: cleared only by reset.

Optional Feature:
ANS_ENC_STATS_EN
- Defined: adds output ports sym_count[15:0] and nib_count[15:0].
  - sym_count counts accepted symbols; nib_count counts transferred nibbles.
  - Both reset to 0 and wrap at 2^16.
  - Both are cleared on INIT entry after a flush.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Model pmf {8,4,2,2} for symbols 0..3, M=16. Send 0, then 3 with in_last -> out nibbles E,1,0,0,0; ans_decoder fed this stream outputs 3 then 0.
- Single symbol 1 (f=4, c=8) with in_last -> x=(16/4)*16+8+0=72; out 8,4,0,0 and no stack nibbles.
- out_rdy held low 10 cycles during FLUSH_STATE -> out/out_vld stable; no nibble lost or duplicated; out_vld low >= 1 cycle between transfers.
- read_rdy delayed 5 cycles on every query -> read_type/read_query held stable; identical output to the zero-delay run.
- STACK_DEPTH=2 with 3 forced renorms -> err_ovf=1 and stays 1 until rst_n pulse.
- rst_n asserted during FLUSH_STACK -> outputs at reset values asynchronously; next message encodes from x=M cleanly.

Source files
------------

// File: rtl/ans_encoder.sv
// Streaming rANS encoder whose nibble stream is consumed directly by ans_decoder.
// Optional ANS_ENC_STATS_EN adds sym_count/nib_count output ports.
module ans_encoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int STATE_WIDTH = 16,
  parameter int STACK_DEPTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic [SYM_WIDTH-1:0]           in,
  input  logic                           in_last,
  input  logic                           in_vld,
  output logic                           in_rdy,
  output logic [SYM_WIDTH-1:0]           out,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [1:0]                     read_type,
  output logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query,
  input  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result,
  input  logic                           read_rdy,
  output logic                           err_ovf
`ifdef ANS_ENC_STATS_EN
  ,
  output logic [15:0]                    sym_count,
  output logic [15:0]                    nib_count
`endif
);

  localparam int RW        = CNT_WIDTH + SYM_WIDTH;
  localparam int W         = STATE_WIDTH + RW;
  localparam int SYM_COUNT = 1 << SYM_WIDTH;
  localparam int NIBS      = STATE_WIDTH / SYM_WIDTH;
  localparam int NW        = $clog2(NIBS + 1);
  localparam int SPW       = $clog2(STACK_DEPTH + 1);
  localparam int AW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] RT_NONE = 2'd0;
  localparam logic [1:0] RT_CMF  = 2'd1;
  localparam logic [1:0] RT_PMF  = 2'd2;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_GET_PMF, S_GET_CMF, S_RENORM, S_ENCODE, S_FLUSH_STATE, S_FLUSH_STACK
  } state_t;

  state_t                 state, state_nxt;
  logic [STATE_WIDTH-1:0] x, x_nxt;
  logic [RW-1:0]          m, m_nxt, f, f_nxt, c, c_nxt, f_div;
  logic [SYM_WIDTH-1:0]   s, s_nxt, out_nxt, stack_top;
  logic                   last, last_nxt, in_rdy_nxt, out_vld_nxt, err_ovf_nxt;
  logic [1:0]             read_type_nxt;
  logic [RW-1:0]          read_query_nxt;
  logic [SPW-1:0]         sp, sp_nxt;
  logic [NW-1:0]          nib_idx, nib_idx_nxt;
  logic                   push_en, renorm_need;
  logic [W-1:0]           quo, rem, enc_val;
  logic [SYM_WIDTH-1:0]   stack [STACK_DEPTH];

  // f is never zero in ENCODE; the guard only keeps the idle divider defined.
  assign f_div       = (f == '0) ? RW'(1) : f;
  assign quo         = W'(x) / W'(f_div);
  assign rem         = W'(x) % W'(f_div);
  assign enc_val     = quo * W'(m) + W'(c) + rem;
  assign renorm_need = (W'(x) >= (W'(f) << SYM_WIDTH));
  assign stack_top   = stack[AW'(sp - SPW'(1))];

  always_comb begin
    state_nxt      = state;
    x_nxt          = x;
    m_nxt          = m;
    f_nxt          = f;
    c_nxt          = c;
    s_nxt          = s;
    last_nxt       = last;
    in_rdy_nxt     = in_rdy;
    out_nxt        = out;
    out_vld_nxt    = out_vld;
    read_type_nxt  = read_type;
    read_query_nxt = read_query;
    err_ovf_nxt    = err_ovf;
    sp_nxt         = sp;
    nib_idx_nxt    = nib_idx;
    push_en        = 1'b0;
    unique case (state)
      S_INIT: begin
        if (read_type == RT_NONE) begin
          read_type_nxt  = RT_CMF;
          read_query_nxt = RW'(SYM_COUNT - 1);
        end else if (read_rdy) begin
          read_type_nxt = RT_NONE;
          m_nxt         = read_result;
          x_nxt         = STATE_WIDTH'(read_result);
          in_rdy_nxt    = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (in_vld && in_rdy) begin
          s_nxt      = in;
          last_nxt   = in_last;
          in_rdy_nxt = 1'b0;
          state_nxt  = S_GET_PMF;
        end
      end
      S_GET_PMF: begin
        if (read_type == RT_NONE) begin
          read_type_nxt  = RT_PMF;
          read_query_nxt = RW'(s);
        end else if (read_rdy) begin
          read_type_nxt = RT_NONE;
          f_nxt         = read_result;
          // A zero-frequency symbol cannot be coded; drop it and flag the error.
          if (read_result == '0) begin
            err_ovf_nxt = 1'b1;
            if (last) begin
              nib_idx_nxt = '0;
              state_nxt   = S_FLUSH_STATE;
            end else begin
              in_rdy_nxt = 1'b1;
              state_nxt  = S_IDLE;
            end
          end else if (s == '0) begin
            c_nxt     = '0;
            state_nxt = S_RENORM;
          end else begin
            state_nxt = S_GET_CMF;
          end
        end
      end
      S_GET_CMF: begin
        if (read_type == RT_NONE) begin
          read_type_nxt  = RT_CMF;
          read_query_nxt = RW'(s) - RW'(1);
        end else if (read_rdy) begin
          read_type_nxt = RT_NONE;
          c_nxt         = read_result;
          state_nxt     = S_RENORM;
        end
      end
      S_RENORM: begin
        if (renorm_need) begin
          if (sp == SPW'(STACK_DEPTH)) begin
            err_ovf_nxt = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_nxt  = sp + SPW'(1);
          end
          x_nxt = x >> SYM_WIDTH;
        end else begin
          state_nxt = S_ENCODE;
        end
      end
      S_ENCODE: begin
        x_nxt = STATE_WIDTH'(enc_val);
        if (last) begin
          nib_idx_nxt = '0;
          state_nxt   = S_FLUSH_STATE;
        end else begin
          in_rdy_nxt = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_FLUSH_STATE: begin
        // out_vld drops after every transfer, giving the decoder its idle cycle.
        if (out_vld) begin
          if (out_rdy) begin
            out_vld_nxt = 1'b0;
            x_nxt       = x >> SYM_WIDTH;
            if (nib_idx == NW'(NIBS - 1)) state_nxt = S_FLUSH_STACK;
            else nib_idx_nxt = nib_idx + NW'(1);
          end
        end else begin
          out_vld_nxt = 1'b1;
          out_nxt     = x[SYM_WIDTH-1:0];
        end
      end
      S_FLUSH_STACK: begin
        if (out_vld) begin
          if (out_rdy) begin
            out_vld_nxt = 1'b0;
            sp_nxt      = sp - SPW'(1);
          end
        end else if (sp == '0) begin
          state_nxt = S_INIT;
        end else begin
          out_vld_nxt = 1'b1;
          out_nxt     = stack_top;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      x          <= '0;
      m          <= '0;
      f          <= '0;
      c          <= '0;
      s          <= '0;
      last       <= 1'b0;
      in_rdy     <= 1'b0;
      out        <= '0;
      out_vld    <= 1'b0;
      read_type  <= RT_NONE;
      read_query <= '0;
      err_ovf    <= 1'b0;
      sp         <= '0;
      nib_idx    <= '0;
    end else if (ena) begin
      state      <= state_nxt;
      x          <= x_nxt;
      m          <= m_nxt;
      f          <= f_nxt;
      c          <= c_nxt;
      s          <= s_nxt;
      last       <= last_nxt;
      in_rdy     <= in_rdy_nxt;
      out        <= out_nxt;
      out_vld    <= out_vld_nxt;
      read_type  <= read_type_nxt;
      read_query <= read_query_nxt;
      err_ovf    <= err_ovf_nxt;
      sp         <= sp_nxt;
      nib_idx    <= nib_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (ena && push_en) stack[AW'(sp)] <= x[SYM_WIDTH-1:0];
  end

`ifdef ANS_ENC_STATS_EN
  // Both counters restart on the INIT entry that closes a message's flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_count <= '0;
      nib_count <= '0;
    end else if (ena) begin
      if (state == S_FLUSH_STACK && !out_vld && sp == '0) begin
        sym_count <= '0;
        nib_count <= '0;
      end else begin
        if (state == S_IDLE && in_vld && in_rdy) sym_count <= sym_count + 16'd1;
        if (out_vld && out_rdy) nib_count <= nib_count + 16'd1;
      end
    end
  end
`endif

endmodule
